// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: prioritised stall/flush/freeze controller for the five-stage pipeline
// Ports: clk_i, start_i (async active-low reset); load-use inputs ID_EX_MemRead_i,
// ID_EX_RDaddr_i, IF_ID_RS1addr_i, IF_ID_RS2addr_i; branch_taken_i; mem_stall_i, mem_ack_i.
// Outputs: PCWrite_o, IF_ID_Write_o, IF_ID_Flush_o, ID_EX_Bubble_o, pipe_freeze_o, err_o,
// state_o (0 RUN, 1 MEM_WAIT, 2 ERROR).
// Optional macro PIPE_PERF_EN adds saturating freeze_cnt_o, bubble_cnt_o, flush_cnt_o.
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk_i,
    input  logic        start_i,
    input  logic        ID_EX_MemRead_i,
    input  logic [4:0]  ID_EX_RDaddr_i,
    input  logic [4:0]  IF_ID_RS1addr_i,
    input  logic [4:0]  IF_ID_RS2addr_i,
    input  logic        branch_taken_i,
    input  logic        mem_stall_i,
    input  logic        mem_ack_i,
    output logic        PCWrite_o,
    output logic        IF_ID_Write_o,
    output logic        IF_ID_Flush_o,
    output logic        ID_EX_Bubble_o,
    output logic        pipe_freeze_o,
    output logic        err_o,
`ifdef PIPE_PERF_EN
    output logic [31:0] freeze_cnt_o,
    output logic [31:0] bubble_cnt_o,
    output logic [31:0] flush_cnt_o,
`endif
    output logic [1:0]  state_o
);
    typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, ERROR = 2'd2} state_t;
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W:0]   cnt_inc;
    logic             lu, freeze;
    assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);
    assign lu = ID_EX_MemRead_i && ID_EX_RDaddr_i != 5'd0 &&
                (ID_EX_RDaddr_i == IF_ID_RS1addr_i || ID_EX_RDaddr_i == IF_ID_RS2addr_i);
    // An ack in MEM_WAIT releases the freeze in the same cycle so the load data is captured.
    assign freeze = (state == RUN && mem_stall_i && !mem_ack_i) ||
                    (state == MEM_WAIT && !mem_ack_i) || state == ERROR;
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (state == RUN) begin
            cnt_nx   = '0;
            state_nx = (mem_stall_i && !mem_ack_i) ? MEM_WAIT : RUN;
        end else if (state == MEM_WAIT) begin
            if (mem_ack_i) begin
                state_nx = RUN;
                cnt_nx   = '0;
            end else if (cnt_inc >= (CNT_W+1)'(TIMEOUT)) begin
                state_nx = ERROR;
            end else begin
                cnt_nx = (&cnt) ? cnt : cnt_inc[CNT_W-1:0];
            end
        end
    end
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end
    // A branch coinciding with a load-use stall is dropped; ID re-presents it next cycle.
    always_comb begin
        PCWrite_o      = !(freeze || lu);
        IF_ID_Write_o  = !(freeze || lu);
        ID_EX_Bubble_o = !freeze && lu;
        IF_ID_Flush_o  = !freeze && !lu && branch_taken_i;
        pipe_freeze_o  = freeze;
        err_o          = state == ERROR;
        state_o        = state;
    end
`ifdef PIPE_PERF_EN
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            freeze_cnt_o <= '0;
            bubble_cnt_o <= '0;
            flush_cnt_o  <= '0;
        end else begin
            freeze_cnt_o <= freeze_cnt_o + {31'd0, pipe_freeze_o && !(&freeze_cnt_o)};
            bubble_cnt_o <= bubble_cnt_o + {31'd0, ID_EX_Bubble_o && !(&bubble_cnt_o)};
            flush_cnt_o  <= flush_cnt_o + {31'd0, IF_ID_Flush_o && !(&flush_cnt_o)};
        end
    end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
    logic clk_i = 1'b0, start_i = 1'b0;
    logic mr = 1'b0, br = 1'b0, stall = 1'b0, ack = 1'b0;
    logic [4:0] rd = '0, rs1 = '0, rs2 = '0;
    logic pcw, ifw, fl, bub, frz, err, pcw_t, ifw_t, fl_t, bub_t, frz_t, err_t;
    logic [1:0] st, st_t;
    int tests = 0, fails = 0;
`ifdef PIPE_PERF_EN
    logic [31:0] fc, bc, lc, fc_t, bc_t, lc_t;
`endif
    localparam logic [5:0] NORM = 6'b110000, BUB = 6'b000100, FLU = 6'b111000,
                           FRZ = 6'b000010, ERRV = 6'b000011;
    wire [5:0] obs   = {pcw, ifw, fl, bub, frz, err};
    wire [5:0] obs_t = {pcw_t, ifw_t, fl_t, bub_t, frz_t, err_t};
    always #5 clk_i = ~clk_i;
    pipe_hazard_ctrl dut (.clk_i(clk_i), .start_i(start_i), .ID_EX_MemRead_i(mr),
        .ID_EX_RDaddr_i(rd), .IF_ID_RS1addr_i(rs1), .IF_ID_RS2addr_i(rs2),
        .branch_taken_i(br), .mem_stall_i(stall), .mem_ack_i(ack), .PCWrite_o(pcw),
        .IF_ID_Write_o(ifw), .IF_ID_Flush_o(fl), .ID_EX_Bubble_o(bub), .pipe_freeze_o(frz),
`ifdef PIPE_PERF_EN
        .freeze_cnt_o(fc), .bubble_cnt_o(bc), .flush_cnt_o(lc),
`endif
        .err_o(err), .state_o(st));
    pipe_hazard_ctrl #(.TIMEOUT(3)) dut_t (.clk_i(clk_i), .start_i(start_i),
        .ID_EX_MemRead_i(mr), .ID_EX_RDaddr_i(rd), .IF_ID_RS1addr_i(rs1),
        .IF_ID_RS2addr_i(rs2), .branch_taken_i(br), .mem_stall_i(stall), .mem_ack_i(ack),
        .PCWrite_o(pcw_t), .IF_ID_Write_o(ifw_t), .IF_ID_Flush_o(fl_t),
        .ID_EX_Bubble_o(bub_t), .pipe_freeze_o(frz_t),
`ifdef PIPE_PERF_EN
        .freeze_cnt_o(fc_t), .bubble_cnt_o(bc_t), .flush_cnt_o(lc_t),
`endif
        .err_o(err_t), .state_o(st_t));
    task automatic step;
        @(posedge clk_i);
        #1;
    endtask
    task automatic test_reset;
        #23;
        tests++; if (obs !== NORM) begin fails++; $display("FAIL reset_obs got=%b exp=%b", obs, NORM); end
        tests++; if (st !== 2'd0 || st_t !== 2'd0) begin fails++; $display("FAIL reset_state got=%0d/%0d exp=0", st, st_t); end
`ifdef PIPE_PERF_EN
        tests++; if (fc !== 0 || bc !== 0 || lc !== 0) begin fails++; $display("FAIL reset_perf got=%0d/%0d/%0d exp=0", fc, bc, lc); end
`endif
        @(negedge clk_i);
        start_i = 1'b1;
        step();
    endtask
    task automatic test_load_use;
        mr = 1; rd = 5; rs1 = 5; rs2 = 0;
        @(negedge clk_i);
        tests++; if (obs !== BUB) begin fails++; $display("FAIL lu_rs1 got=%b exp=%b", obs, BUB); end
        step();
        mr = 0;
        @(negedge clk_i);
        tests++; if (obs !== NORM) begin fails++; $display("FAIL lu_after got=%b exp=%b", obs, NORM); end
        step();
        mr = 1; rd = 7; rs1 = 3; rs2 = 7;
        @(negedge clk_i);
        tests++; if (obs !== BUB) begin fails++; $display("FAIL lu_rs2 got=%b exp=%b", obs, BUB); end
        step();
        mr = 0; rd = 7; rs1 = 7; rs2 = 7;
        @(negedge clk_i);
        tests++; if (obs !== NORM) begin fails++; $display("FAIL lu_noload got=%b exp=%b", obs, NORM); end
        step();
    endtask
    task automatic test_x0;
        mr = 1; rd = 0; rs1 = 0; rs2 = 0;
        @(negedge clk_i);
        tests++; if (obs !== NORM) begin fails++; $display("FAIL x0_guard got=%b exp=%b", obs, NORM); end
        step();
        mr = 0;
    endtask
    task automatic test_branch_lu;
        mr = 1; rd = 9; rs1 = 9; br = 1;
        @(negedge clk_i);
        tests++; if (obs !== BUB) begin fails++; $display("FAIL br_lu got=%b exp=%b", obs, BUB); end
        step();
        mr = 0;
        @(negedge clk_i);
        tests++; if (obs !== FLU) begin fails++; $display("FAIL br_flush got=%b exp=%b", obs, FLU); end
        step();
        br = 0; rd = 0; rs1 = 0;
    endtask
    task automatic test_mem_wait;
        stall = 1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk_i);
            tests++; if (obs !== FRZ || st !== (c == 1 ? 2'd0 : 2'd1)) begin fails++; $display("FAIL memwait_c%0d got=%b/%0d exp=%b/%0d", c, obs, st, FRZ, (c == 1 ? 0 : 1)); end
            step();
        end
        ack = 1;
        @(negedge clk_i);
        tests++; if (obs !== NORM || st !== 2'd1) begin fails++; $display("FAIL memwait_ack got=%b/%0d exp=%b/1", obs, st, NORM); end
        step();
        ack = 0; stall = 0;
        @(negedge clk_i);
        tests++; if (obs !== NORM || st !== 2'd0) begin fails++; $display("FAIL memwait_run got=%b/%0d exp=%b/0", obs, st, NORM); end
        step();
    endtask
    task automatic test_perf;
`ifdef PIPE_PERF_EN
        tests++; if (bc !== 32'd3) begin fails++; $display("FAIL perf_bubble got=%0d exp=3", bc); end
        tests++; if (lc !== 32'd1) begin fails++; $display("FAIL perf_flush got=%0d exp=1", lc); end
        tests++; if (fc !== 32'd4) begin fails++; $display("FAIL perf_freeze got=%0d exp=4", fc); end
`endif
    endtask
    task automatic test_watchdog;
        start_i = 0;
        #1;
        start_i = 1;
        stall = 1;
        @(negedge clk_i);
        tests++; if (obs_t !== FRZ || st_t !== 2'd0) begin fails++; $display("FAIL wd_req got=%b/%0d exp=%b/0", obs_t, st_t, FRZ); end
        step(); step(); step();
        stall = 0; ack = 1;
        @(negedge clk_i);
        tests++; if (obs_t !== NORM || st_t !== 2'd1) begin fails++; $display("FAIL wd_short_ack got=%b/%0d exp=%b/1", obs_t, st_t, NORM); end
        step();
        ack = 0; stall = 1;
        for (int e = 0; e < 3; e++) begin
            step();
            tests++; if (st_t !== 2'd1 || err_t !== 1'b0) begin fails++; $display("FAIL wd_wait_e%0d got=%0d/%b exp=1/0", e, st_t, err_t); end
        end
        step();
        tests++; if (st_t !== 2'd2 || obs_t !== ERRV) begin fails++; $display("FAIL wd_error got=%0d/%b exp=2/%b", st_t, obs_t, ERRV); end
        tests++; if (st !== 2'd1) begin fails++; $display("FAIL wd_main_wait got=%0d exp=1", st); end
        stall = 0; ack = 1;
        @(negedge clk_i);
        tests++; if (obs_t !== ERRV || obs !== NORM) begin fails++; $display("FAIL wd_ack_ignored got=%b/%b exp=%b/%b", obs_t, obs, ERRV, NORM); end
        step();
        ack = 0; stall = 1;
        @(negedge clk_i);
        tests++; if (st_t !== 2'd2 || st !== 2'd0) begin fails++; $display("FAIL wd_sticky got=%0d/%0d exp=2/0", st_t, st); end
        step();
        ack = 1; start_i = 0;
        #1;
        tests++; if (st_t !== 2'd0 || err_t !== 1'b0 || st !== 2'd0 || obs !== NORM) begin fails++; $display("FAIL wd_async_rst got=%0d/%b/%0d/%b exp=0/0/0/%b", st_t, err_t, st, obs, NORM); end
        ack = 0; stall = 0;
        #2;
        start_i = 1;
        step();
        tests++; if (st !== 2'd0 || obs !== NORM) begin fails++; $display("FAIL wd_ack_discard got=%0d/%b exp=0/%b", st, obs, NORM); end
    endtask
    initial begin
        #100000;
        $display("FAIL tb_timeout");
        $fatal(1, "timeout");
    end
    initial begin
        test_reset();
        test_load_use();
        test_x0();
        test_branch_lu();
        test_mem_wait();
        test_perf();
        test_watchdog();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the five-stage pipeline. It combines load-use hazard detection, ID-stage branch flush and data-memory wait requests into one prioritised set of control strobes for the PC, IF/ID and ID/EX registers, and a global freeze for the later stages. A small FSM tracks multi-cycle memory waits, guarded by a watchdog.

## Interface
Parameters:
- TIMEOUT, 255: maximum MEM_WAIT cycles before the watchdog fires (1..2^CNT_W-1).
- CNT_W, 8: width of the wait counter.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- start_i  in  1  reset; asynchronous, active-low.
- ID_EX_MemRead_i  in  1  instruction in EX is a load.
- ID_EX_RDaddr_i  in  5  destination register of the instruction in EX.
- IF_ID_RS1addr_i  in  5  rs1 of the instruction in ID.
- IF_ID_RS2addr_i  in  5  rs2 of the instruction in ID.
- branch_taken_i  in  1  branch in ID resolved taken.
- mem_stall_i  in  1  MEM-stage access cannot complete this cycle.
- mem_ack_i  in  1  single-cycle pulse: outstanding access completes this cycle.
- PCWrite_o  out  1  PC may update.
- IF_ID_Write_o  out  1  IF/ID may capture.
- IF_ID_Flush_o  out  1  IF/ID loads a NOP.
- ID_EX_Bubble_o  out  1  ID/EX control fields forced to 0.
- pipe_freeze_o  out  1  ID/EX, EX/MEM and MEM/WB hold their values.
- err_o  out  1  sticky watchdog error.
- state_o  out  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 ERROR.

## Operation
- Load-use hazard: `lu = ID_EX_MemRead_i && ID_EX_RDaddr_i != 0 && (ID_EX_RDaddr_i == IF_ID_RS1addr_i || ID_EX_RDaddr_i == IF_ID_RS2addr_i)`.
- FSM:
  - RUN -> MEM_WAIT when mem_stall_i=1 and mem_ack_i=0.
  - MEM_WAIT -> RUN on mem_ack_i=1.
  - MEM_WAIT -> ERROR when the wait counter reaches TIMEOUT without an ack.
  - ERROR holds until reset.
- Wait counter: cleared on entry to MEM_WAIT; increments each MEM_WAIT cycle; saturates; cleared in RUN.
- Output priority, highest first (outputs are combinational from state and inputs):
  1. freeze = (state==RUN && mem_stall_i && !mem_ack_i) || (state==MEM_WAIT && !mem_ack_i) || state==ERROR. While freeze: PCWrite_o=0, IF_ID_Write_o=0, pipe_freeze_o=1, IF_ID_Flush_o=0, ID_EX_Bubble_o=0.
  2. lu (not frozen): PCWrite_o=0, IF_ID_Write_o=0, ID_EX_Bubble_o=1, IF_ID_Flush_o=0. A branch_taken_i in the same cycle is ignored and re-evaluated the next cycle.
  3. branch_taken_i: PCWrite_o=1, IF_ID_Write_o=1, IF_ID_Flush_o=1.
  4. Otherwise: PCWrite_o=1, IF_ID_Write_o=1, all other strobes 0.
- Ack cycle in MEM_WAIT: freeze is released in that same cycle, so the pipeline captures the memory data; mem_stall_i is ignored in that cycle.
- err_o=1 exactly when state==ERROR.

## Timing
- Reset (start_i=0, asynchronous): state=RUN, counter=0, err_o=0, perf counters=0.
- Output values during reset follow RUN with no stall: with inputs idle, PCWrite_o=1, IF_ID_Write_o=1, all other strobes 0, state_o=0.
- Hazard response latency is 0 cycles; strobes are valid in the same cycle as the inputs.
- Load-use produces exactly one bubble cycle, because the bubble clears ID_EX_MemRead_i on the next edge.
- MEM_WAIT of N cycles followed by an ack in cycle N+1 gives a freeze of N+1 cycles, counting the request cycle.
- With TIMEOUT=T and no ack: ERROR is entered on the T-th rising edge spent in MEM_WAIT; err_o rises immediately after that edge.
- start_i asserted mid-wait returns the block to RUN asynchronously; any pending ack is discarded.

## Configuration
- PIPE_PERF_EN defined: adds three outputs, all saturating, all cleared by reset:
  - freeze_cnt_o[31:0]: cycles with pipe_freeze_o=1.
  - bubble_cnt_o[31:0]: cycles with ID_EX_Bubble_o=1.
  - flush_cnt_o[31:0]: cycles with IF_ID_Flush_o=1.
- PIPE_PERF_EN undefined: these ports and their counters do not exist; all other behaviour is identical.

## Test plan
- Load-use: ID_EX_MemRead_i=1, RDaddr=5, RS1=5 for one cycle, then MemRead=0 -> one cycle with PCWrite_o=0, IF_ID_Write_o=0, ID_EX_Bubble_o=1, then normal strobes.
- x0 guard: RDaddr=0, RS1=0, MemRead=1 -> no bubble, PCWrite_o=1.
- Branch with load-use in the same cycle: branch_taken_i=1 and lu=1 -> Bubble=1, Flush=0; next cycle with lu=0 and branch=1 -> Flush=1, PCWrite_o=1.
- Memory wait: mem_stall_i=1 for 4 cycles, ack in cycle 5 -> pipe_freeze_o=1 for cycles 1-4 and 0 in cycle 5; state_o sequence 0,1,1,1,1,0; counter=0 after return to RUN.
- Watchdog: TIMEOUT=3, mem_stall_i held, no ack -> state_o=2 and err_o=1 after 3 MEM_WAIT edges; an ack pulse then has no effect; start_i low clears state_o and err_o to 0 immediately.
- PIPE_PERF_EN: run the scenarios above in sequence -> bubble_cnt_o=2 and flush_cnt_o=1, with freeze_cnt_o matching the number of frozen cycles counted on the bench.
